// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and defaults for the slice-serial wide add/subtract sequencer.
// Holds the FSM encoding, the default geometry and the index-width helper.
package multiword_add_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_SLICE_W    = 6;
   localparam int DEF_NUM_SLICES = 4;

   // A single-slice configuration still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multiword_add_sequencer_adder_slice.sv
// Combinational SLICE_W-bit ripple-carry adder used once per cycle by the sequencer.
// Also exposes the carry into its MSB so the caller can form signed overflow.
module adder_slice
   import multiword_add_sequencer_pkg::*;
#(
   parameter int W = DEF_SLICE_W
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         CIN,
   output logic [W-1:0] SUM,
   output logic         COUT,
   output logic         C_MSB
);

   always_comb begin
      logic c;
      SUM   = '0;
      C_MSB = 1'b0;
      c     = CIN;
      for (int i = 0; i < W; i++) begin
         if (i == W - 1) C_MSB = c;
         SUM[i] = A[i] ^ B[i] ^ c;
         c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
      end
      COUT = c;
   end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract computed LSB-first, one SLICE_W slice per clock, on a single adder slice.
// Carry is chained between cycles in a register; result is held until the next accepted start.
module multiword_add_sequencer
   import multiword_add_sequencer_pkg::*;
#(
   parameter  int SLICE_W    = DEF_SLICE_W,
   parameter  int NUM_SLICES = DEF_NUM_SLICES,
   localparam int TOTAL_W    = SLICE_W * NUM_SLICES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               SUB,
   input  logic [TOTAL_W-1:0] A,
   input  logic [TOTAL_W-1:0] B,
   output logic               ready,
   output logic               done,
   output logic [TOTAL_W-1:0] SUM,
   output logic               COUT,
   output logic               OVF
);

   localparam int IDX_W = idx_width(NUM_SLICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   state_t                    state_reg, state_next;
   logic [IDX_W-1:0]          idx_reg;
   logic                      carry_reg;
   logic [TOTAL_W-1:0]        a_sh_reg, b_sh_reg, res_sh_reg, sum_reg;
   logic                      cout_reg, ovf_reg;

   logic [SLICE_W-1:0]        slice_sum;
   logic                      slice_cout, slice_c_msb;
   logic [TOTAL_W+SLICE_W-1:0] res_cat;
   logic                      last_slice;

   adder_slice #(.W(SLICE_W)) u_slice (
      .A     (a_sh_reg[SLICE_W-1:0]),
      .B     (b_sh_reg[SLICE_W-1:0]),
      .CIN   (carry_reg),
      .SUM   (slice_sum),
      .COUT  (slice_cout),
      .C_MSB (slice_c_msb)
   );

   // New slice enters at the top; after NUM_SLICES shifts slice 0 sits at the LSB.
   assign res_cat    = {slice_sum, res_sh_reg};
   assign last_slice = (idx_reg == LAST_IDX);

   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            ready = 1'b1;
            if (start) state_next = RUN;
         end
         RUN: begin
            if (last_slice) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         idx_reg    <= '0;
         carry_reg  <= 1'b0;
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         res_sh_reg <= '0;
         sum_reg    <= '0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
                  a_sh_reg  <= A;
                  b_sh_reg  <= SUB ? ~B : B;
                  carry_reg <= SUB;
                  idx_reg   <= '0;
               end
            end
            RUN: begin
               res_sh_reg <= res_cat[TOTAL_W+SLICE_W-1:SLICE_W];
               a_sh_reg   <= a_sh_reg >> SLICE_W;
               b_sh_reg   <= b_sh_reg >> SLICE_W;
               carry_reg  <= slice_cout;
               idx_reg    <= idx_reg + 1'b1;
               if (last_slice) begin
                  sum_reg  <= res_cat[TOTAL_W+SLICE_W-1:SLICE_W];
                  cout_reg <= slice_cout;
                  ovf_reg  <= slice_c_msb ^ slice_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign SUM  = sum_reg;
   assign COUT = cout_reg;
   assign OVF  = ovf_reg;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed vector bench for multiword_add_sequencer at default geometry (6-bit slices x 4).
// Table-driven arithmetic vectors plus hand-written busy, reset-abort and reset-priority sequences.
module tb_multiword_add_sequencer;

   localparam int TOTAL_W = 24;
   localparam int EXP_LAT = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               SUB;
   logic [TOTAL_W-1:0] A, B;
   logic               ready, done;
   logic [TOTAL_W-1:0] SUM;
   logic               COUT, OVF;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string              name;
      logic               sub;
      logic [TOTAL_W-1:0] a;
      logic [TOTAL_W-1:0] b;
      logic [TOTAL_W-1:0] sum;
      logic               cout;
      logic               ovf;
   } vec_t;

   vec_t vecs[9];

   multiword_add_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .SUB   (SUB),
      .A     (A),
      .B     (B),
      .ready (ready),
      .done  (done),
      .SUM   (SUM),
      .COUT  (COUT),
      .OVF   (OVF)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Issue one op at a negedge, wait for done (bounded), then check result and return to IDLE.
   task automatic do_op(input string name, input logic sub, input logic [TOTAL_W-1:0] a,
                        input logic [TOTAL_W-1:0] b, input logic [TOTAL_W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
      int lat;
      @(negedge clk);
      check({name, "_ready_before"}, 32'(ready), 32'd1);
      start = 1'b1; SUB = sub; A = a; B = b;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      check({name, "_done_latency"}, 32'(lat), 32'(EXP_LAT));
      check({name, "_sum"}, 32'(SUM), 32'(exp_sum));
      check({name, "_cout"}, 32'(COUT), 32'(exp_cout));
      check({name, "_ovf"}, 32'(OVF), 32'(exp_ovf));
      @(negedge clk);
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
      check({name, "_ready_after"}, 32'(ready), 32'd1);
      check({name, "_sum_held"}, 32'(SUM), 32'(exp_sum));
      $display("op %-10s sub=%0d a=%h b=%h -> sum=%h cout=%0d ovf=%0d lat=%0d",
               name, sub, a, b, SUM, COUT, OVF, lat);
   endtask

   initial begin
      int lat;
      int pulses;

      vecs[0] = '{"add_small", 1'b0, 24'h000003, 24'h00000B, 24'h00000E, 1'b0, 1'b0};
      vecs[1] = '{"carry_s01", 1'b0, 24'h00003F, 24'h000001, 24'h000040, 1'b0, 1'b0};
      vecs[2] = '{"wrap_all",  1'b0, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0};
      vecs[3] = '{"ovf_pos",   1'b0, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b1};
      vecs[4] = '{"sub_neg",   1'b1, 24'h000005, 24'h000007, 24'hFFFFFE, 1'b0, 1'b0};
      vecs[5] = '{"sub_pos",   1'b1, 24'h000009, 24'h000004, 24'h000005, 1'b1, 1'b0};
      vecs[6] = '{"sub_ovf",   1'b1, 24'h800000, 24'h000001, 24'h7FFFFF, 1'b1, 1'b1};
      vecs[7] = '{"sub_zero",  1'b1, 24'h000000, 24'h000000, 24'h000000, 1'b1, 1'b0};
      vecs[8] = '{"add_mixed", 1'b0, 24'h123456, 24'h654321, 24'h777777, 1'b0, 1'b0};

      reset = 1'b1; start = 1'b0; SUB = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(SUM), 32'd0);
      check("rst_cout", 32'(COUT), 32'd0);
      check("rst_ovf", 32'(OVF), 32'd0);

      foreach (vecs[i])
         do_op(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b,
               vecs[i].sum, vecs[i].cout, vecs[i].ovf);

      // Busy: a second start with different operands during RUN must be ignored.
      @(negedge clk);
      start = 1'b1; SUB = 1'b0; A = 24'd1; B = 24'd2;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) begin A = 24'd100; B = 24'd100; end
         if (n == 1) check("busy_ready_low", 32'(ready), 32'd0);
         if (n == 3) start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      check("busy_done_latency", 32'(lat), 32'(EXP_LAT));
      check("busy_sum", 32'(SUM), 32'd3);
      $display("op busy       a=000001 b=000002 (restart 100+100 ignored) -> sum=%h lat=%0d", SUM, lat);

      // Leave nonzero COUT/OVF/SUM so the abort below visibly clears them.
      do_op("pre_abort", 1'b1, 24'h800000, 24'h000001, 24'h7FFFFF, 1'b1, 1'b1);

      // Reset at the second RUN cycle aborts the op with no done pulse.
      @(negedge clk);
      start = 1'b1; SUB = 1'b0; A = 24'd5; B = 24'd6;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(SUM), 32'd0);
      check("abort_cout", 32'(COUT), 32'd0);
      check("abort_ovf", 32'(OVF), 32'd0);
      pulses = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
      $display("op abort      a=000005 b=000006 reset mid-RUN -> sum=%h done_pulses=%0d", SUM, pulses);

      // Reset and start together in IDLE: reset wins, nothing is started.
      @(negedge clk);
      reset = 1'b1; start = 1'b1; A = 24'd1; B = 24'd1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("prio_ready", 32'(ready), 32'd1);
      pulses = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("prio_no_done", 32'(pulses), 32'd0);
      check("prio_sum", 32'(SUM), 32'd0);
      $display("op prio      reset+start same cycle -> ready=%0d done_pulses=%0d", ready, pulses);

      // The sequencer must still work after the aborts.
      do_op("post_abort", 1'b0, 24'h00003F, 24'h00003F, 24'h00007E, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
